// File: rtl/cluster_packer_seq.sv
// Sequential S-bit cluster packer: one cluster slot per clock4x cycle from a buffered frame,
// with a one-deep pending buffer, ready backpressure, overflow flag and saturating drop counter.
module cluster_packer_seq #(
  parameter int NUM_VFATS      = 24,
  parameter int SBITS_PER_VFAT = 64,
  parameter int MAX_CLUSTERS   = 8,
  parameter int CNT_BITS       = 3,
  parameter int ADR_BITS       = 11,
  parameter int SPLIT_AT_VFAT  = 0,
  parameter int DROP_CNT_BITS  = 16
) (
  input  logic                                         clock4x,
  input  logic                                         global_reset_n,
  input  logic [NUM_VFATS*SBITS_PER_VFAT-1:0]          sbits,
  input  logic                                         sbits_valid,
  output logic                                         sbits_ready,
  input  logic                                         reverse_priority_order,
  input  logic                                         truncate_clusters,
  output logic [MAX_CLUSTERS*(CNT_BITS+ADR_BITS)-1:0]  clusters,
  output logic                                         clusters_valid,
  output logic [$clog2(MAX_CLUSTERS+1)-1:0]            cluster_count,
  output logic                                         overflow,
  output logic [DROP_CNT_BITS-1:0]                     drop_cnt
);
  localparam int N    = NUM_VFATS * SBITS_PER_VFAT;
  localparam int W    = CNT_BITS + ADR_BITS;
  localparam int CAP  = 2 ** CNT_BITS;
  localparam int CC_W = $clog2(MAX_CLUSTERS + 1);
  localparam logic [N-1:0] ONE          = N'(1);
  localparam logic [W-1:0] INVALID_SLOT = {{CNT_BITS{1'b0}}, {ADR_BITS{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_EXTRACT, S_PUBLISH} state_t;

  state_t                     r_state;
  logic [N-1:0]               r_work, r_pend;
  logic                       r_work_trunc, r_work_rev, r_pend_trunc, r_pend_rev, r_pend_full;
  logic [CC_W-1:0]            r_slot_idx, r_count, r_cluster_count;
  logic [MAX_CLUSTERS*W-1:0]  r_stage, r_clusters;
  logic                       r_valid, r_overflow;
  logic [DROP_CNT_BITS-1:0]   r_drop;

  // Reverse order is handled by storing the frame bit-reversed, so one upward extractor serves both.
  function automatic logic [N-1:0] f_reverse(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) f_reverse[i] = v[N-1-i];
  endfunction

  logic [N-1:0]          w_in_norm, w_low, w_run, w_win, w_chunk, w_clear;
  logic [ADR_BITS-1:0]   w_a, w_adr;
  logic [CAP-1:0]        w_seg;
  logic [CNT_BITS:0]     w_size;
  logic [W-1:0]          w_slot;
  logic                  w_any, w_pend_load, w_work_load_in;

  assign w_in_norm = reverse_priority_order ? f_reverse(sbits) : sbits;
  assign w_any     = |r_work;
  assign w_low     = r_work & (~r_work + ONE);
  // Adding the lowest set bit ripples through the lowest run, so this isolates that run.
  assign w_run     = r_work & ~(r_work + w_low);

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_a = '0;
    for (int i = N - 1; i >= 0; i--) if (r_work[i]) w_a = ADR_BITS'(i);
  end

  for (genvar v = 0; v < NUM_VFATS; v++) begin : g_win
    assign w_win[v*SBITS_PER_VFAT +: SBITS_PER_VFAT] = {SBITS_PER_VFAT{(SPLIT_AT_VFAT == 0) ||
        (int'(w_a) >= v * SBITS_PER_VFAT && int'(w_a) < (v + 1) * SBITS_PER_VFAT)}};
  end

  assign w_chunk = w_run & w_win & ((w_low << CAP) - w_low);
  assign w_seg   = CAP'(w_chunk >> w_a);
  assign w_size  = (CNT_BITS+1)'($countones(w_seg));
  assign w_clear = r_work_trunc ? (w_run & w_win) : w_chunk;
  assign w_adr   = r_work_rev ? (ADR_BITS'(N) - w_a - ADR_BITS'(w_size)) : w_a;
  assign w_slot  = {CNT_BITS'(w_size - (CNT_BITS+1)'(1)), w_adr};

  assign sbits_ready    = !r_pend_full || (r_state == S_PUBLISH);
  assign w_pend_load    = sbits_valid && sbits_ready &&
                          ((r_state == S_EXTRACT) || (r_state == S_PUBLISH && r_pend_full));
  assign w_work_load_in = sbits_valid &&
                          ((r_state == S_IDLE) || (r_state == S_PUBLISH && !r_pend_full));

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clock4x) begin
    if (!global_reset_n) begin
      r_state         <= S_IDLE;
      // NOTE: the wide frame buffers are reset too, since a reset must discard any half-processed frame.
      r_work          <= '0;
      r_pend          <= '0;
      r_work_trunc    <= 1'b0;
      r_work_rev      <= 1'b0;
      r_pend_trunc    <= 1'b0;
      r_pend_rev      <= 1'b0;
      r_pend_full     <= 1'b0;
      r_slot_idx      <= '0;
      r_count         <= '0;
      r_stage         <= {MAX_CLUSTERS{INVALID_SLOT}};
      r_clusters      <= {MAX_CLUSTERS{INVALID_SLOT}};
      r_cluster_count <= '0;
      r_valid         <= 1'b0;
      r_overflow      <= 1'b0;
      r_drop          <= '0;
    end else begin
      r_valid <= 1'b0;
      if (sbits_valid && !sbits_ready && r_drop != '1) r_drop <= r_drop + DROP_CNT_BITS'(1);

      if (w_pend_load) begin
        r_pend       <= w_in_norm;
        r_pend_rev   <= reverse_priority_order;
        r_pend_trunc <= truncate_clusters;
        r_pend_full  <= 1'b1;
      end else if (r_state == S_PUBLISH && r_pend_full) begin
        r_pend_full  <= 1'b0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_work_load_in) begin
            r_work       <= w_in_norm;
            r_work_rev   <= reverse_priority_order;
            r_work_trunc <= truncate_clusters;
            r_slot_idx   <= '0;
            r_count      <= '0;
            r_state      <= S_EXTRACT;
          end
        end
        S_EXTRACT: begin
          for (int k = 0; k < MAX_CLUSTERS; k++)
            if (r_slot_idx == CC_W'(k)) r_stage[k*W +: W] <= w_any ? w_slot : INVALID_SLOT;
          if (w_any) begin
            r_work  <= r_work & ~w_clear;
            r_count <= r_count + CC_W'(1);
          end
          r_slot_idx <= r_slot_idx + CC_W'(1);
          if (r_slot_idx == CC_W'(MAX_CLUSTERS - 1)) r_state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          r_clusters      <= r_stage;
          r_cluster_count <= r_count;
          r_overflow      <= w_any;
          r_valid         <= 1'b1;
          r_slot_idx      <= '0;
          r_count         <= '0;
          if (r_pend_full) begin
            r_work       <= r_pend;
            r_work_rev   <= r_pend_rev;
            r_work_trunc <= r_pend_trunc;
            r_state      <= S_EXTRACT;
          end else if (w_work_load_in) begin
            r_work       <= w_in_norm;
            r_work_rev   <= reverse_priority_order;
            r_work_trunc <= truncate_clusters;
            r_state      <= S_EXTRACT;
          end else begin
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clusters       = r_clusters;
  assign clusters_valid = r_valid;
  assign cluster_count  = r_cluster_count;
  assign overflow       = r_overflow;
  assign drop_cnt       = r_drop;
endmodule

// File: tb/tb_cluster_packer_seq.sv
// Scoreboard bench for cluster_packer_seq: a bit-walking reference model fills per-DUT queues,
// publishes are popped and compared on the falling edge.
module tb_cluster_packer_seq;
  localparam int NV = 24, SB = 64, N = NV * SB, MC = 8, CB = 3, AB = 11, W = CB + AB, CAP = 8, DB = 16;
  localparam int CW = $clog2(MC + 1);
  localparam logic [MC*W-1:0] RST_BANK = {MC{14'h07FF}};

  typedef logic [N-1:0] frame_t;
  typedef struct {
    logic [MC*W-1:0] clus;
    logic [CW-1:0]   cnt;
    logic            ovf;
    int              exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, valid0, valid1, rev_i, trunc_i;
  frame_t          sbits;
  logic            ready0, ready1, cv0, cv1, ovf0, ovf1;
  logic [MC*W-1:0] clus0, clus1;
  logic [CW-1:0]   cnt0, cnt1;
  logic [DB-1:0]   drop0, drop1;

  cluster_packer_seq dut0 (
    .clock4x(clk), .global_reset_n(rst_n), .sbits(sbits), .sbits_valid(valid0), .sbits_ready(ready0),
    .reverse_priority_order(rev_i), .truncate_clusters(trunc_i), .clusters(clus0),
    .clusters_valid(cv0), .cluster_count(cnt0), .overflow(ovf0), .drop_cnt(drop0));

  cluster_packer_seq #(.SPLIT_AT_VFAT(1)) dut1 (
    .clock4x(clk), .global_reset_n(rst_n), .sbits(sbits), .sbits_valid(valid1), .sbits_ready(ready1),
    .reverse_priority_order(rev_i), .truncate_clusters(trunc_i), .clusters(clus1),
    .clusters_valid(cv1), .cluster_count(cnt1), .overflow(ovf1), .drop_cnt(drop1));

  int     n_cmp = 0, n_err = 0, cyc = 0;
  bit     sb_en = 1'b1;
  exp_t   q0[$], q1[$];
  frame_t f, f_a, f_b, f_c;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input frame_t fr, input bit rev, input bit trunc, input bit split);
    exp_t   e;
    frame_t m = fr;
    int     n = 0;
    e.clus = '0;
    for (int k = 0; k < MC; k++) begin
      logic [W-1:0] slot;
      int p, start, size, step, adr;
      slot = 14'h07FF;
      if (m != '0) begin
        step = rev ? -1 : 1;
        p = rev ? N - 1 : 0;
        while (!m[p]) p += step;
        start = p;
        size = 0;
        while (p >= 0 && p < N && m[p] &&
               !(split && p != start && (rev ? ((p + 1) % SB == 0) : (p % SB == 0)))) begin
          if (size < CAP) begin size++; m[p] = 1'b0; end
          else if (trunc) m[p] = 1'b0;
          else break;
          p += step;
        end
        adr = rev ? start - size + 1 : start;
        slot = {CB'(size - 1), AB'(adr)};
        n++;
      end
      e.clus[k*W +: W] = slot;
    end
    e.cnt = CW'(n);
    e.ovf = (m != '0);
    e.exp_cyc = -1;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cv0 && sb_en) begin
      check("dut0_publish_expected", q0.size() != 0, 1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("dut0_clusters", clus0, e.clus);
        check("dut0_count", cnt0, e.cnt);
        check("dut0_overflow", ovf0, e.ovf);
        if (e.exp_cyc >= 0) check("dut0_latency", cyc, e.exp_cyc);
      end
    end
    if (cv1 && sb_en) begin
      check("dut1_publish_expected", q1.size() != 0, 1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("dut1_clusters", clus1, e.clus);
        check("dut1_count", cnt1, e.cnt);
        check("dut1_overflow", ovf1, e.ovf);
      end
    end
  end

  task automatic send(input frame_t fr, input bit rev, input bit trunc, input bit to_split,
                      input bit accept, input int lat);
    exp_t e;
    @(negedge clk);
    sbits = fr; rev_i = rev; trunc_i = trunc;
    if (to_split) valid1 = 1'b1; else valid0 = 1'b1;
    @(posedge clk); #1;
    valid0 = 1'b0; valid1 = 1'b0;
    if (accept) begin
      e = model(fr, rev, trunc, to_split);
      e.exp_cyc = (lat < 0) ? -1 : cyc + lat;
      if (to_split) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((q0.size() + q1.size()) != 0 && t < 200) begin @(negedge clk); t++; end
    check(tag, q0.size() + q1.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_clusters"}, clus0, RST_BANK);
    check({tag, "_valid"}, cv0, 0);
    check({tag, "_count"}, cnt0, 0);
    check({tag, "_overflow"}, ovf0, 0);
    check({tag, "_ready"}, ready0, 1);
    check({tag, "_drop"}, drop0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; valid0 = 1'b0; valid1 = 1'b0; rev_i = 1'b0; trunc_i = 1'b0; sbits = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    f = '0; f[3:0] = 4'hF;
    send(f, 0, 0, 0, 1, 9); drain("t1_drain");

    f = {(N/2){2'b01}};
    send(f, 0, 0, 0, 1, 9); drain("t2_normal_drain");
    send(f, 1, 0, 0, 1, 9); drain("t2_reverse_drain");

    f = '0; f[111:100] = '1;
    send(f, 0, 0, 0, 1, 9); drain("t3_plain_drain");
    send(f, 0, 1, 0, 1, 9); drain("t3_trunc_drain");
    send(f, 1, 0, 0, 1, 9); drain("t3_reverse_drain");

    f = '0; f[65:62] = '1;
    send(f, 0, 0, 1, 1, -1); drain("t4_split_drain");
    send(f, 1, 1, 1, 1, -1); drain("t4_split_rev_drain");
    send(f, 0, 0, 0, 1, 9);  drain("t4_nosplit_drain");

    f = '0; f[N-1 -: 11] = '1; f[2:0] = '1;
    send(f, 0, 0, 0, 1, 9); drain("top_normal_drain");
    send(f, 1, 1, 0, 1, 9); drain("top_reverse_trunc_drain");
    send(f, 1, 0, 1, 1, -1); drain("top_reverse_split_drain");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) f[i] = r[0] ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      send(f, r[1], r[2], r >= 6, 1, -1);
      drain("rand_drain");
    end

    f_a = '0; f_a[10] = 1'b1;
    f_b = '0; f_b[20:17] = '1; f_b[900] = 1'b1;
    f_c = '0; f_c[500:490] = '1;
    send(f_a, 0, 0, 0, 1, 9);
    send(f_b, 1, 0, 0, 1, 17);
    check("t5_ready_low", ready0, 0);
    send(f_c, 0, 0, 0, 0, -1);
    check("t5_drop_one", drop0, 1);
    drain("t5_drain");

    sb_en = 1'b0;
    @(negedge clk);
    sbits = f_c; valid0 = 1'b1;
    repeat (80000) @(negedge clk);
    valid0 = 1'b0;
    repeat (40) @(negedge clk);
    sb_en = 1'b1;
    check("t5_drop_saturated", drop0, 16'hFFFF);
    check("t5_ready_after_stress", ready0, 1);

    send(f_b, 0, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_reset_state("t6_mid_reset");
    send(f_b, 0, 0, 0, 1, 9); drain("t6_after_reset_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
